// File: rtl/apb_uart_req_arbiter.sv
// Round-robin arbiter sharing the UART APB slave port between NUM_REQ requesters.
// Each grant runs one SETUP/ACCESS transfer; read data returns to the owner.
module apb_uart_req_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [DATA_W-1:0]         prdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_vld;
  logic             accept;
  logic             lock_active;
  logic             lock_hold;
  logic [CNT_W-1:0] lock_cnt;
  int unsigned      scan;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    grant_vld   = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    scan        = 0;

    // A live lock pins arbitration to the previous owner, even if it is not requesting.
    lock_hold = lock_active && (lock_cnt < CNT_W'(LOCK_MAX)) && req_lock_i[last_grant];

    for (int unsigned i = 1; i <= unsigned'(NUM_REQ); i++) begin
      scan = 32'(last_grant) + i;
      if (scan >= unsigned'(NUM_REQ)) scan = scan - unsigned'(NUM_REQ);
      cand = IDX_W'(scan);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end

    if (lock_hold) begin
      grant_vld = req_valid_i[last_grant];
      grant_idx = last_grant;
    end

    accept = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          accept                 = 1'b1;
          req_ready_o[grant_idx] = 1'b1;
          state_nxt              = SETUP;
        end
      end
      SETUP: begin
        psel_o    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= IDX_W'(NUM_REQ - 1);
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pwrite_o    <= 1'b0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= '0;

      if (accept) begin
        paddr_o     <= req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
        pwdata_o    <= req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
        pwrite_o    <= req_write_i[grant_idx];
        last_grant  <= grant_idx;
        lock_active <= req_lock_i[grant_idx];
        // The count includes the grant that opened the run, so an owner gets LOCK_MAX in a row.
        lock_cnt    <= lock_hold ? lock_cnt + CNT_W'(1) : CNT_W'(1);
      end else if (state == IDLE && lock_active && !lock_hold) begin
        lock_active <= 1'b0;
      end

      if (state == ACCESS) begin
        rsp_valid_o[last_grant] <= 1'b1;
        rsp_rdata_o             <= pwrite_o ? '0 : prdata_i;
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_req_arbiter.sv
// Scoreboard bench for apb_uart_req_arbiter: predicted transfers are queued when
// requests are posted and matched against APB bus activity and responses.
module tb_apb_uart_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, req_write, req_lock, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, pwdata, prdata;
  logic [AW-1:0]    paddr;
  logic             pwrite, psel, penable;

  apb_uart_req_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LOCK_MAX(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_lock_i (req_lock),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .paddr_o    (paddr),
    .pwdata_o   (pwdata),
    .pwrite_o   (pwrite),
    .psel_o     (psel),
    .penable_o  (penable),
    .prdata_i   (prdata)
  );

  always #5 clk = ~clk;

  // UART read data model: a fixed function of the address.
  assign prdata = paddr ^ 32'h0000_0052;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
  } apb_t;

  typedef struct {
    logic [NR-1:0] id1h;
    logic [DW-1:0] rdata;
  } rsp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int            remaining[NR];
  int            seqn[NR];
  logic [AW-1:0] abase[NR];
  logic [DW-1:0] wbase[NR];
  logic          wmode[NR];
  logic          locking[NR];
  logic          hold[NR];

  apb_t apb_q[$];
  rsp_t rsp_q[$];
  int   acc_q[$];
  int   prev_acc;
  bit   tput_on;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int k, input int n);
    return abase[k] + AW'(4 * n);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int k, input int n);
    return wbase[k] + DW'(n);
  endfunction

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid[k]            = remaining[k] > 0;
      req_write[k]            = wmode[k];
      req_lock[k]             = locking[k] && (remaining[k] > 0 || hold[k]);
      req_addr[k*AW +: AW]    = addr_of(k, seqn[k]);
      req_wdata[k*DW +: DW]   = wdata_of(k, seqn[k]);
    end
  endtask

  task automatic expect_xfer(input int k, input int n);
    apb_t a;
    rsp_t r;
    a.addr  = addr_of(k, n);
    a.wdata = wdata_of(k, n);
    a.write = wmode[k];
    r.id1h  = NR'(1) << k;
    r.rdata = wmode[k] ? '0 : (a.addr ^ 32'h0000_0052);
    apb_q.push_back(a);
    rsp_q.push_back(r);
  endtask

  task automatic clear_all();
    for (int k = 0; k < NR; k++) begin
      remaining[k] = 0;
      seqn[k]      = 0;
      locking[k]   = 1'b0;
      hold[k]      = 1'b0;
    end
    apb_q.delete();
    rsp_q.delete();
    acc_q.delete();
    drive();
  endtask

  task automatic at_setup();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_psel"},    64'(psel),      0);
    check_eq({tag, "_penable"}, 64'(penable),   0);
    check_eq({tag, "_paddr"},   64'(paddr),     0);
    check_eq({tag, "_pwdata"},  64'(pwdata),    0);
    check_eq({tag, "_pwrite"},  64'(pwrite),    0);
    check_eq({tag, "_rspv"},    64'(rsp_valid), 0);
    check_eq({tag, "_rdata"},   64'(rsp_rdata), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      done = apb_q.size() == 0 && rsp_q.size() == 0;
      for (int k = 0; k < NR; k++) if (remaining[k] != 0) done = 1'b0;
    end
    check_eq({"drain_", tag}, 64'(done), 1);
  endtask

  task automatic requester_driver();
    logic [NR-1:0] acc;
    forever begin
      @(negedge clk);
      acc = rst ? '0 : (req_ready & req_valid);
      if (acc != '0) begin
        acc_q.push_back(cyc);
        if (tput_on && prev_acc >= 0) check_eq("throughput", 64'(cyc - prev_acc), 3);
        prev_acc = cyc;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (acc[k]) begin
          remaining[k]--;
          seqn[k]++;
        end
      end
      drive();
    end
  endtask

  task automatic bus_monitor();
    apb_t a;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_eq("ready_onehot", 64'($countones(req_ready) <= 1), 1);
        if (penable) check_eq("penable_psel", 64'(psel), 1);
        if (psel && !penable) begin
          check_eq("setup_pending", 64'(acc_q.size() != 0), 1);
          if (acc_q.size() != 0) check_eq("setup_latency", 64'(cyc - acc_q[0]), 1);
        end
        if (psel && penable) begin
          check_eq("apb_expected", 64'(apb_q.size() != 0), 1);
          if (apb_q.size() != 0) begin
            a = apb_q.pop_front();
            check_eq("paddr",  64'(paddr),  64'(a.addr));
            check_eq("pwdata", 64'(pwdata), 64'(a.wdata));
            check_eq("pwrite", 64'(pwrite), 64'(a.write));
          end
        end
        if (rsp_valid != '0) begin
          check_eq("rsp_expected", 64'(rsp_q.size() != 0), 1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check_eq("rsp_valid", 64'(rsp_valid), 64'(r.id1h));
            check_eq("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
          end
          if (acc_q.size() != 0) check_eq("rsp_latency", 64'(cyc - acc_q.pop_front()), 3);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit hit;
    rst      = 1'b1;
    tput_on  = 1'b0;
    prev_acc = -1;
    for (int k = 0; k < NR; k++) begin
      abase[k] = '0;
      wbase[k] = '0;
      wmode[k] = 1'b0;
    end
    clear_all();
    fork
      requester_driver();
      bus_monitor();
    join_none

    repeat (2) @(posedge clk);
    check_reset_outputs("reset");

    // Single write from requester 0.
    at_setup();
    rst = 1'b0;
    abase[0] = 32'h0000_0004; wbase[0] = 32'h0000_00A5; wmode[0] = 1'b1;
    expect_xfer(0, 0);
    remaining[0] = 1;
    drive();
    wait_done("write", 20);

    // Read from requester 1, data 0x5A expected.
    at_setup();
    abase[1] = 32'h0000_0008; wmode[1] = 1'b0; seqn[1] = 0;
    expect_xfer(1, 0);
    remaining[1] = 1;
    drive();
    wait_done("read", 20);

    // Contention from reset: strict alternation, one transfer per 3 cycles.
    at_setup();
    rst = 1'b1;
    clear_all();
    abase[0] = 32'h0000_0100; wbase[0] = 32'h1111_0000; wmode[0] = 1'b1;
    abase[1] = 32'h0000_0200; wbase[1] = 32'h2222_0000; wmode[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      expect_xfer(0, n);
      expect_xfer(1, n);
    end
    remaining[0] = 4; remaining[1] = 4;
    drive();
    @(posedge clk);
    check_reset_outputs("reset2");
    at_setup();
    prev_acc = -1;
    tput_on  = 1'b1;
    rst      = 1'b0;
    wait_done("contention", 60);
    tput_on = 1'b0;

    // Lock: requester 0 gets LOCK_MAX grants, then requester 1 breaks in.
    at_setup();
    clear_all();
    locking[0] = 1'b1;
    for (int n = 0; n < 4; n++) expect_xfer(0, n);
    expect_xfer(1, 0);
    expect_xfer(0, 4);
    expect_xfer(0, 5);
    expect_xfer(1, 1);
    remaining[0] = 6; remaining[1] = 2;
    drive();
    wait_done("lock", 60);

    // Lock wait: idle owner keeps the bus reserved until it drops its lock.
    at_setup();
    clear_all();
    locking[0] = 1'b1; hold[0] = 1'b1;
    expect_xfer(0, 0);
    remaining[0] = 1;
    drive();
    wait_done("lock_owner", 20);
    at_setup();
    expect_xfer(1, 0);
    remaining[1] = 1;
    drive();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("lockwait_psel",  64'(psel),      0);
      check_eq("lockwait_ready", 64'(req_ready), 0);
    end
    at_setup();
    hold[0] = 1'b0;
    drive();
    @(negedge clk);
    check_eq("lockwait_release_ready", 64'(req_ready), 64'(2'b10));
    wait_done("lock_wait", 20);

    // Reset during ACCESS drops the transfer; requester 0 wins afterwards.
    at_setup();
    clear_all();
    expect_xfer(0, 0);
    remaining[0] = 2; remaining[1] = 2;
    drive();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = penable;
    end
    check_eq("reached_access", 64'(hit), 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_psel",    64'(psel),      0);
    check_eq("midrst_penable", 64'(penable),   0);
    check_eq("midrst_rspv",    64'(rsp_valid), 0);
    #1;
    clear_all();
    expect_xfer(1, 0);
    check_reset_outputs("reset3");
    at_setup();
    apb_q.delete();
    rsp_q.delete();
    expect_xfer(0, 0);
    expect_xfer(1, 0);
    remaining[0] = 1; remaining[1] = 1;
    drive();
    rst = 1'b0;
    wait_done("after_reset", 20);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
